multicycle_control: RTL

Parametrised multi-cycle RV32 control unit that sequences FETCH/DECODE/EXEC/MEM/WB through an explicit state machine instead of decoding each instruction combinationally in a single cycle. It drives datapath enables, mux selects and the ALU operation code directly. It handshakes with a variable-latency memory through `mem_ready` and traps on illegal encodings or memory timeouts. It sits between the instruction register and the shared multi-cycle datapath (PC, IR, register file, ALU, memory port).

---
 rtl/ctrl_pkg.sv | 28 ++
 rtl/multicycle_control_if.sv | 34 +++
 rtl/alu_decode.sv | 28 ++
 rtl/multicycle_control.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32 control unit.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath/memory bundle: instruction fields and status in, enables and selects out.
interface multicycle_control_if #(
  parameter int unsigned OP_W = 4
) ();

  logic [6:0]      opcode;
  logic [3:0]      funct;
  logic            zero;
  logic            mem_ready;
  logic            pc_write;
  logic            ir_write;
  logic            mem_read;
  logic            mem_write;
  logic            reg_write;
  logic            mem_to_reg;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [OP_W-1:0] alu_op;
  logic [2:0]      state;
  logic            trap;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, state, trap
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, state, trap
  );

endinterface

// File: rtl/alu_decode.sv
// Maps {instr[30], funct3} to an ALU op; I-type ignores instr[30].
module alu_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W = 4
) (
  input  logic [3:0]      i_funct,
  input  logic            i_is_itype,
  output logic [OP_W-1:0] o_alu_op,
  output logic            o_funct_illegal
);

  logic [3:0] w_funct;

  always_comb begin
    w_funct         = i_is_itype ? {1'b0, i_funct[2:0]} : i_funct;
    o_alu_op        = '0;
    o_funct_illegal = 1'b0;
    case (w_funct)
      4'b0000: o_alu_op = OP_W'(ALU_ADD);
      4'b1000: o_alu_op = OP_W'(ALU_SUB);
      4'b0111: o_alu_op = OP_W'(ALU_AND);
      4'b0110: o_alu_op = OP_W'(ALU_OR);
      default: o_funct_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB with memory-wait timeout and sticky trap.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W     = 4,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned EN_ITYPE = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.master bus
);

  localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [6:0]        r_opcode;
  logic [3:0]        r_funct;
  logic              w_op_legal;
  logic              w_timeout;
  logic              w_is_itype;
  logic              w_funct_illegal;
  logic [OP_W-1:0]   w_alu_op_fn;

  logic              w_pc_write;
  logic              w_ir_write;
  logic              w_mem_read;
  logic              w_mem_write;
  logic              w_reg_write;
  logic              w_mem_to_reg;
  logic              w_alu_src_a;
  logic [1:0]        w_alu_src_b;
  logic [OP_W-1:0]   w_alu_op;
  logic              w_trap;

  assign w_is_itype = (r_opcode == OP_IMM);

  // Timeout fires on the wait cycle that would bring the counter to MAX_WAIT.
  assign w_timeout = (MAX_WAIT != 0) && !bus.mem_ready &&
                     (r_cnt == CNT_W'(MAX_WAIT - 1));

  always_comb begin
    case (bus.opcode)
      OP_R, OP_LOAD, OP_STORE, OP_BRANCH: w_op_legal = 1'b1;
      OP_IMM:                             w_op_legal = (EN_ITYPE != 0);
      default:                            w_op_legal = 1'b0;
    endcase
  end

  alu_decode #(.OP_W(OP_W)) u_alu_decode (
    .i_funct         (r_funct),
    .i_is_itype      (w_is_itype),
    .o_alu_op        (w_alu_op_fn),
    .o_funct_illegal (w_funct_illegal)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Instruction fields captured once, in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= '0;
      r_funct  <= '0;
    end else if (r_state == S_DECODE) begin
      r_opcode <= bus.opcode;
      r_funct  <= bus.funct;
    end
  end

  // Memory wait counter: cleared on any state change, counts stalled FETCH/MEM cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if ((r_state == S_FETCH || r_state == S_MEM) && !bus.mem_ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready)  w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_DECODE: w_next = w_op_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (r_opcode)
          OP_R, OP_IMM:      w_next = w_funct_illegal ? S_TRAP : S_WB;
          OP_LOAD, OP_STORE: w_next = S_MEM;
          OP_BRANCH:         w_next = S_FETCH;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready)  w_next = (r_opcode == OP_LOAD) ? S_WB : S_FETCH;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_WB:    w_next = S_FETCH;
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  // Output decode; FETCH load strobes and branch pc_write are the only input-dependent terms
  always_comb begin
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRC_B_RS2;
    w_alu_op     = '0;
    w_trap       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRC_B_FOUR;
        w_alu_op    = OP_W'(ALU_ADD);
        w_ir_write  = bus.mem_ready && rst_n;
        w_pc_write  = bus.mem_ready && rst_n;
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        case (r_opcode)
          OP_R: begin
            w_alu_op = w_alu_op_fn;
          end
          OP_IMM: begin
            w_alu_src_b = SRC_B_IMM;
            w_alu_op    = w_alu_op_fn;
          end
          OP_LOAD, OP_STORE: begin
            w_alu_src_b = SRC_B_IMM;
            w_alu_op    = OP_W'(ALU_ADD);
          end
          OP_BRANCH: begin
            w_alu_op   = OP_W'(ALU_SUB);
            w_pc_write = bus.zero;
          end
          default: w_alu_src_a = 1'b0;
        endcase
      end
      S_MEM: begin
        w_mem_read  = (r_opcode == OP_LOAD);
        w_mem_write = (r_opcode == OP_STORE);
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (r_opcode == OP_LOAD);
      end
      S_TRAP:  w_trap = 1'b1;
      default: ;
    endcase
  end

  assign bus.pc_write   = w_pc_write;
  assign bus.ir_write   = w_ir_write;
  assign bus.mem_read   = w_mem_read;
  assign bus.mem_write  = w_mem_write;
  assign bus.reg_write  = w_reg_write;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.state      = r_state;
  assign bus.trap       = w_trap;

endmodule
